clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable integer clock divider for the clock-generation path. It produces the divided clock `clk_o` and a one-cycle `tick_o` enable, both synchronous to `clk`. The divisor is run-time programmable and resets to 4. Divisor changes take effect only at a period boundary, so `clk_o` never glitches and never has a short phase. It sits upstream of the fixed dividers and of the slow-domain logic, and replaces hard-wired divide chains wherever the ratio must be configurable.

## Interface
- `WIDTH`, default 8: width of the divisor and of the internal counter. Legal divisors are 1 .. 2^WIDTH-1.
- `clk`, input, 1: source clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Assert at any time; release synchronously to `clk`.
- `en`, input, 1: count enable. 0 freezes the divider.
- `load_i`, input, 1: one-cycle request to take `div_i` as the new divisor.
- `div_i`, input, WIDTH: requested divisor, sampled when `load_i`=1.
- `clk_o`, output, 1: divided clock, registered.
- `tick_o`, output, 1: one-cycle pulse on every `clk_o` period start, registered.
- `div_o`, output, WIDTH: divisor currently in effect.
- `pend_o`, output, 1: a validated load is waiting for the next boundary.
- `err_o`, output, 1: one-cycle pulse when a load with `div_i`=0 is rejected.

## Operation
- State:
  - `cnt`, WIDTH bits.
  - `div_cur`, WIDTH bits.
  - `div_pend`, WIDTH bits.
  - `pend`, 1 bit.
  - `clk_o`, `tick_o`, `err_o`, all registered.
- Reset values:
  - `div_cur`=4, `cnt`=3 (that is, `div_cur`-1).
  - `div_pend`=0, `pend`=0.
  - `clk_o`=0, `tick_o`=0, `err_o`=0.
  - `div_o`=4, `pend_o`=0.
- High-phase length: `hi_len` = (`div_cur`+1)>>1, computed in WIDTH+1 bits so 2^WIDTH-1 does not overflow. Odd divisors get the extra cycle in the high phase.
- Wrap edge: an enabled edge with `cnt` >= `div_cur`-1. Using >= keeps the counter safe if `cnt` ever exceeds the divisor. On a wrap edge:
  - If `pend`=1 before the edge: `div_cur` <= `div_pend` and `pend` <= 0.
  - `cnt` <= 0, `clk_o` <= 1, `tick_o` <= 1.
  - The new divisor governs the period that starts at this edge.
- Non-wrap enabled edge:
  - `cnt` <= `cnt`+1.
  - `clk_o` <= (`cnt`+1 < `hi_len`).
  - `tick_o` <= 0.
- `en`=0 edge:
  - `cnt`, `div_cur` and `clk_o` hold.
  - `tick_o` <= 0.
  - Load capture still operates.
- Load capture, on any edge with `load_i`=1:
  - `div_i`!=0: `div_pend` <= `div_i`, `pend` <= 1. A later load before the boundary overwrites the earlier one (latest wins).
  - `div_i`=0: no state change; `err_o` <= 1 for one cycle.
  - `err_o` <= 0 on every other edge.
- Load and wrap on the same edge: the wrap uses the old `pend`/`div_pend`. The new value is captured and applied at the following wrap.
- Divisor 1: every enabled edge wraps, so `clk_o` stays 1 and `tick_o` is 1 on every enabled cycle.

## Timing
- First enabled edge after reset release is a wrap edge: `clk_o` rises and `tick_o`=1.
- `tick_o` is high in exactly the cycle in which `clk_o` has just risen.
- Period is exactly `div_cur` enabled cycles.
- `clk_o` is high for `hi_len` cycles and low for `div_cur`-`hi_len` cycles.
- Load latency:
  - `pend_o` rises the cycle after the `load_i` edge.
  - `div_o` changes on the first wrap edge after that, at the latest `div_cur` enabled cycles later.
- Reset mid-period: all outputs go to their reset values immediately and asynchronously, and any pending load is discarded.

## Test plan
- Reset release, `en`=1 throughout, default divisor: `clk_o` pattern 1,1,0,0 repeating; `tick_o` on cycles 1, 5, 9; `div_o`=4.
- Load `div_i`=3 at `cnt`=1, with divisor 4:
  - The current period completes at 4 cycles.
  - Following periods are high 2 cycles, low 1 cycle.
  - `pend_o` is 1 from the cycle after the load until the wrap edge.
- Load `div_i`=1, then later `div_i`=255:
  - With divisor 1: `clk_o` constant 1 and `tick_o` every cycle.
  - With divisor 255: high 128 cycles, low 127 cycles.
- Load `div_i`=0: `err_o` pulses for exactly one cycle; `div_o`, `pend_o` and the `clk_o` pattern are unchanged.
- Two loads (6, then 5) within one period, the second on the wrap edge: the next period uses 6, the one after uses 5.
- `en`=0 for 3 cycles mid high phase: `clk_o` holds 1, `tick_o`=0, the period stretches by 3 cycles.
- Assert `rst`=0 mid-period with a load pending: `clk_o`=0 immediately; after release `div_o`=4 and `pend_o`=0.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider with glitch-free divisor updates.
// Divisor changes are staged and applied only at a period boundary.
module clk_div_prog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic [WIDTH-1:0] div_o,
    output logic             pend_o,
    output logic             err_o
);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
    logic [WIDTH-1:0] cnt_q, cnt_d, div_cur_q, div_cur_d, div_pend_q, div_pend_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, err_q, err_d;
    logic [WIDTH:0]   hi_len, cnt_inc;
    logic             wrap, load_ok;
    always_comb begin
        hi_len     = ({1'b0, div_cur_q} + ONE) >> 1;
        cnt_inc    = {1'b0, cnt_q} + ONE;
        // cnt >= div_cur-1, written as cnt+1 >= div_cur to avoid underflow
        wrap       = en && (cnt_inc >= {1'b0, div_cur_q});
        load_ok    = load_i && (div_i != '0);
        cnt_d      = wrap ? '0 : (en ? cnt_inc[WIDTH-1:0] : cnt_q);
        div_cur_d  = (wrap && pend_q) ? div_pend_q : div_cur_q;
        div_pend_d = load_ok ? div_i : div_pend_q;
        pend_d     = load_ok || (pend_q && !wrap);
        clk_d      = wrap || (en ? (cnt_inc < hi_len) : clk_q);
        tick_d     = wrap;
        err_d      = load_i && (div_i == '0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= WIDTH'(3);
            div_cur_q  <= WIDTH'(4);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end
    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign div_o  = div_cur_q;
    assign pend_o = pend_q;
    assign err_o  = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed bench for clk_div_prog with a remaining-cycles reference model.
module tb_clk_div_prog;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, load_i = 1'b0;
    logic [7:0] div_i = 8'd0;
    logic       clk_o, tick_o, pend_o, err_o;
    logic [7:0] div_o;
    int n_cmp = 0, n_bad = 0;
    int exp_clk4[9]  = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
    int exp_tick4[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_clk3[6]  = '{1, 0, 1, 1, 0, 1};
    logic [7:0] m_div, m_pdiv;
    int         m_rem;
    logic       m_pend, m_clk, m_tick, m_err;

    always #5 clk = ~clk;

    clk_div_prog #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .load_i(load_i), .div_i(div_i),
        .clk_o(clk_o), .tick_o(tick_o), .div_o(div_o), .pend_o(pend_o), .err_o(err_o)
    );

    // Model tracks cycles remaining in the current period; position = div - 1 - remaining.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_div <= 8'd4; m_pdiv <= 8'd0; m_rem <= 0; m_pend <= 1'b0;
            m_clk <= 1'b0; m_tick <= 1'b0; m_err <= 1'b0;
        end else begin
            m_err <= load_i && (div_i == 8'd0);
            if (en && m_rem == 0) begin
                m_div  <= m_pend ? m_pdiv : m_div;
                m_rem  <= int'(m_pend ? m_pdiv : m_div) - 1;
                m_pend <= 1'b0;
                m_clk  <= 1'b1;
                m_tick <= 1'b1;
            end else if (en) begin
                m_rem  <= m_rem - 1;
                m_clk  <= (int'(m_div) - m_rem) < ((int'(m_div) + 1) / 2);
                m_tick <= 1'b0;
            end else
                m_tick <= 1'b0;
            if (load_i && div_i != 8'd0) begin
                m_pend <= 1'b1;
                m_pdiv <= div_i;
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n_cmp++;
        if ({clk_o, tick_o, div_o, pend_o, err_o} !== {m_clk, m_tick, m_div, m_pend, m_err}) begin
            n_bad++;
            $display("FAIL model @%0t: dut clk=%b tick=%b div=%0d pend=%b err=%b, model clk=%b tick=%b div=%0d pend=%b err=%b",
                     $time, clk_o, tick_o, div_o, pend_o, err_o, m_clk, m_tick, m_div, m_pend, m_err);
        end
    endtask

    initial begin
        int hi, lo, cnt;
        repeat (3) step();
        lit("rst_clk", clk_o, 0); lit("rst_tick", tick_o, 0); lit("rst_div", div_o, 4);
        lit("rst_pend", pend_o, 0); lit("rst_err", err_o, 0);
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            lit($sformatf("div4_clk%0d", i), clk_o, exp_clk4[i]);
            lit($sformatf("div4_tick%0d", i), tick_o, exp_tick4[i]);
        end
        lit("div4_div", div_o, 4);
        step();
        load_i = 1'b1; div_i = 8'd3; step(); load_i = 1'b0;
        lit("ld3_pend", pend_o, 1); lit("ld3_div_old", div_o, 4);
        step();
        lit("ld3_pend2", pend_o, 1); lit("ld3_clk_low", clk_o, 0);
        step();
        lit("ld3_div", div_o, 3); lit("ld3_pend_clr", pend_o, 0); lit("ld3_tick", tick_o, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            lit($sformatf("div3_clk%0d", i), clk_o, exp_clk3[i]);
        end
        load_i = 1'b1; div_i = 8'd0; step(); load_i = 1'b0;
        lit("err_pulse", err_o, 1); lit("err_div", div_o, 3); lit("err_pend", pend_o, 0);
        step();
        lit("err_clear", err_o, 0);
        load_i = 1'b1; div_i = 8'd1; step(); load_i = 1'b0;
        lit("ld1_pend", pend_o, 1);
        cnt = 0;
        while (div_o != 8'd1 && cnt < 10) begin step(); cnt++; end
        lit("ld1_div", div_o, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            lit($sformatf("div1_clk%0d", i), clk_o, 1);
            lit($sformatf("div1_tick%0d", i), tick_o, 1);
        end
        load_i = 1'b1; div_i = 8'd255; step(); load_i = 1'b0;
        step();
        lit("ld255_div", div_o, 255); lit("ld255_tick", tick_o, 1);
        hi = 1; cnt = 0;
        while (clk_o && cnt < 300) begin step(); if (clk_o) hi++; cnt++; end
        lo = 1;
        while (!clk_o && cnt < 600) begin step(); if (!clk_o) lo++; cnt++; end
        lit("div255_high", hi, 128); lit("div255_low", lo, 127);
        load_i = 1'b1; div_i = 8'd4; step(); load_i = 1'b0;
        cnt = 0;
        while (div_o != 8'd4 && cnt < 300) begin step(); cnt++; end
        lit("back_to_4", div_o, 4);
        load_i = 1'b1; div_i = 8'd6; step(); load_i = 1'b0;
        step(); step();
        load_i = 1'b1; div_i = 8'd5; step(); load_i = 1'b0;
        lit("two_ld_div6", div_o, 6); lit("two_ld_pend", pend_o, 1); lit("two_ld_tick", tick_o, 1);
        repeat (5) step();
        lit("two_ld_div6_hold", div_o, 6);
        step();
        lit("two_ld_div5", div_o, 5); lit("two_ld_tick5", tick_o, 1); lit("two_ld_pend_clr", pend_o, 0);
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            lit($sformatf("frz_clk%0d", i), clk_o, 1);
            lit($sformatf("frz_tick%0d", i), tick_o, 0);
        end
        en = 1'b1;
        cnt = 4;
        do begin step(); cnt++; end while (!tick_o && cnt < 20);
        lit("frz_period", cnt, 8);
        load_i = 1'b1; div_i = 8'd7; step(); load_i = 1'b0;
        lit("prerst_pend", pend_o, 1); lit("prerst_clk", clk_o, 1);
        #2 rst = 1'b0;
        #1;
        lit("arst_clk", clk_o, 0); lit("arst_tick", tick_o, 0); lit("arst_div", div_o, 4);
        lit("arst_pend", pend_o, 0); lit("arst_err", err_o, 0);
        step(); step();
        rst = 1'b1;
        step();
        lit("rel_tick", tick_o, 1); lit("rel_clk", clk_o, 1); lit("rel_div", div_o, 4); lit("rel_pend", pend_o, 0);
        repeat (12) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
